// File: rtl/eeg_chip_dat_unpacker.sv
// Chip-side ingress stage. Splits command beats onto a single-entry cmd register and
// packs data beats into RATIO-lane words queued in a small FIFO.
module eeg_chip_dat_unpacker #(
    parameter int DW         = 8,
    parameter int RATIO      = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = $clog2(RATIO + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_dat_vld,
    input  logic                  chip_dat_lst,
    input  logic                  chip_dat_cmd,
    input  logic [DW-1:0]         chip_dat_dat,
    output logic                  chip_dat_rdy,
    output logic                  cmd_vld,
    output logic [DW-1:0]         cmd_dat,
    input  logic                  cmd_rdy,
    output logic                  pkt_vld,
    output logic                  pkt_lst,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [RATIO*DW-1:0]   pkt_dat,
    input  logic                  pkt_rdy,
    output logic [15:0]           pkt_num
);

    // state | meaning
    // IDLE  | lane counter at 0, no partial word held
    // FILL  | partial word holds lanes 0..lane_q-1, waiting for lane lane_q
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_t;

    localparam int LANE_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int AW     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    pack_state_t           state_q;
    logic [LANE_W-1:0]     lane_q;
    logic [RATIO*DW-1:0]   part_q;
    logic [RATIO*DW-1:0]   word_next;

    logic                  cmd_vld_q;
    logic [DW-1:0]         cmd_dat_q;

    logic [RATIO*DW-1:0]   fifo_dat [FIFO_DEPTH];
    logic                  fifo_lst [FIFO_DEPTH];
    logic [CNT_W-1:0]      fifo_cnt [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [15:0]           pkt_num_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  acc_beat;
    logic                  acc_cmd;
    logic                  acc_data;
    logic                  word_done;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      push_cnt;

    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);

    // No bypass: a full FIFO refuses data even if the head is popped this cycle.
    assign chip_dat_rdy = !rst && (chip_dat_cmd ? (!cmd_vld_q || cmd_rdy) : !fifo_full);

    assign acc_beat  = chip_dat_vld && chip_dat_rdy;
    assign acc_cmd   = acc_beat && chip_dat_cmd;
    assign acc_data  = acc_beat && !chip_dat_cmd;
    assign word_done = chip_dat_lst || (lane_q == LANE_W'(RATIO - 1));
    assign push      = acc_data && word_done;
    assign pop       = !rst && !fifo_empty && pkt_rdy;
    assign push_cnt  = CNT_W'(lane_q) + CNT_W'(1);

    // Lanes above the current one stay zero because part_q is cleared after each push.
    always_comb begin
        word_next = part_q;
        word_next[lane_q*DW +: DW] = chip_dat_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            part_q  <= '0;
        end else if (acc_data) begin
            case (state_q)
                IDLE: begin
                    if (word_done) begin
                        part_q <= '0;
                    end else begin
                        state_q <= FILL;
                        lane_q  <= LANE_W'(1);
                        part_q  <= word_next;
                    end
                end
                FILL: begin
                    if (word_done) begin
                        state_q <= IDLE;
                        lane_q  <= '0;
                        part_q  <= '0;
                    end else begin
                        lane_q <= lane_q + LANE_W'(1);
                        part_q <= word_next;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lane_q  <= '0;
                    part_q  <= '0;
                end
            endcase
        end
    end

    // A reload in the same cycle as a consume keeps the register occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_q <= 1'b0;
            cmd_dat_q <= '0;
        end else if (acc_cmd) begin
            cmd_vld_q <= 1'b1;
            cmd_dat_q <= chip_dat_dat;
        end else if (cmd_vld_q && cmd_rdy) begin
            cmd_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_dat[i] <= '0;
                fifo_lst[i] <= 1'b0;
                fifo_cnt[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_dat[wr_ptr[AW-1:0]] <= word_next;
                fifo_lst[wr_ptr[AW-1:0]] <= chip_dat_lst;
                fifo_cnt[wr_ptr[AW-1:0]] <= push_cnt;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_num_q <= '0;
        end else if (pop && fifo_lst[rd_ptr[AW-1:0]]) begin
            pkt_num_q <= pkt_num_q + 16'd1;
        end
    end

    // Outputs are forced low for the whole reset interval, including its first cycle.
    assign cmd_vld = !rst && cmd_vld_q;
    assign cmd_dat = rst ? '0 : cmd_dat_q;
    assign pkt_vld = !rst && !fifo_empty;
    assign pkt_lst = !rst && fifo_lst[rd_ptr[AW-1:0]];
    assign pkt_cnt = rst ? '0 : fifo_cnt[rd_ptr[AW-1:0]];
    assign pkt_dat = rst ? '0 : fifo_dat[rd_ptr[AW-1:0]];
    assign pkt_num = rst ? '0 : pkt_num_q;

endmodule

// File: tb/tb_eeg_chip_dat_unpacker.sv
// Directed bench for eeg_chip_dat_unpacker with DW=8, RATIO=4, FIFO_DEPTH=4.
module tb_eeg_chip_dat_unpacker;

    logic        clk;
    logic        rst;
    logic        chip_dat_vld;
    logic        chip_dat_lst;
    logic        chip_dat_cmd;
    logic [7:0]  chip_dat_dat;
    logic        chip_dat_rdy;
    logic        cmd_vld;
    logic [7:0]  cmd_dat;
    logic        cmd_rdy;
    logic        pkt_vld;
    logic        pkt_lst;
    logic [2:0]  pkt_cnt;
    logic [31:0] pkt_dat;
    logic        pkt_rdy;
    logic [15:0] pkt_num;

    int tests_run;
    int tests_failed;

    eeg_chip_dat_unpacker #(.DW(8), .RATIO(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .chip_dat_vld (chip_dat_vld),
        .chip_dat_lst (chip_dat_lst),
        .chip_dat_cmd (chip_dat_cmd),
        .chip_dat_dat (chip_dat_dat),
        .chip_dat_rdy (chip_dat_rdy),
        .cmd_vld      (cmd_vld),
        .cmd_dat      (cmd_dat),
        .cmd_rdy      (cmd_rdy),
        .pkt_vld      (pkt_vld),
        .pkt_lst      (pkt_lst),
        .pkt_cnt      (pkt_cnt),
        .pkt_dat      (pkt_dat),
        .pkt_rdy      (pkt_rdy),
        .pkt_num      (pkt_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and holds it until accepted (bounded).
    task automatic send(input logic c, input logic l, input logic [7:0] d);
        int n;
        n = 0;
        chip_dat_vld = 1'b1;
        chip_dat_cmd = c;
        chip_dat_lst = l;
        chip_dat_dat = d;
        #1;
        while (!chip_dat_rdy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk_eq("send_timeout", 32'd0, 32'd1);
        tick();
        chip_dat_vld = 1'b0;
        chip_dat_cmd = 1'b0;
        chip_dat_lst = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [31:0] d, input logic [2:0] c,
                            input logic l);
        int n;
        n = 0;
        while (!pkt_vld && n < 50) begin
            tick();
            n++;
        end
        chk_eq({tag, "_vld"}, 32'(pkt_vld), 32'd1);
        chk_eq({tag, "_dat"}, pkt_dat, d);
        chk_eq({tag, "_cnt"}, 32'(pkt_cnt), 32'(c));
        chk_eq({tag, "_lst"}, 32'(pkt_lst), 32'(l));
        pkt_rdy = 1'b1;
        tick();
        pkt_rdy = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        chip_dat_vld = 1'b1;
        chip_dat_lst = 1'b0;
        chip_dat_cmd = 1'b0;
        chip_dat_dat = 8'h00;
        cmd_rdy      = 1'b0;
        pkt_rdy      = 1'b0;
        #1;
        chk_eq("rst_rdy", 32'(chip_dat_rdy), 32'd0);
        tick();
        tick();
        chk_eq("rst_pkt_vld", 32'(pkt_vld), 32'd0);
        chk_eq("rst_cmd_vld", 32'(cmd_vld), 32'd0);
        chk_eq("rst_pkt_num", 32'(pkt_num), 32'd0);
        chip_dat_vld = 1'b0;
        rst = 1'b0;
        tick();

        // Full word with lst on lane 3
        send(0, 0, 8'h11);
        send(0, 0, 8'h22);
        send(0, 0, 8'h33);
        chk_eq("t1_not_yet", 32'(pkt_vld), 32'd0);
        send(0, 1, 8'h44);
        chk_eq("t1_latency", 32'(pkt_vld), 32'd1);
        pop_word("t1", 32'h44332211, 3'd4, 1'b1);
        chk_eq("t1_empty", 32'(pkt_vld), 32'd0);
        chk_eq("t1_num", 32'(pkt_num), 32'd1);

        // Short packet, then next packet starts at lane 0
        send(0, 0, 8'hA1);
        send(0, 1, 8'hA2);
        pop_word("t2a", 32'h0000A2A1, 3'd2, 1'b1);
        send(0, 1, 8'h55);
        pop_word("t2b", 32'h00000055, 3'd1, 1'b1);

        // Command interleaved with data, second command stalls
        send(0, 0, 8'h01);
        send(0, 0, 8'h02);
        send(1, 0, 8'h5C);
        chk_eq("t3_cmd_vld", 32'(cmd_vld), 32'd1);
        chk_eq("t3_cmd_dat", 32'(cmd_dat), 32'h5C);
        chip_dat_vld = 1'b1;
        chip_dat_cmd = 1'b1;
        chip_dat_dat = 8'h6D;
        #1;
        chk_eq("t3_cmd_stall", 32'(chip_dat_rdy), 32'd0);
        chip_dat_vld = 1'b0;
        chip_dat_cmd = 1'b0;
        send(0, 0, 8'h03);
        send(0, 1, 8'h04);
        pop_word("t3", 32'h04030201, 3'd4, 1'b1);
        chk_eq("t3_cmd_held", 32'(cmd_dat), 32'h5C);
        cmd_rdy = 1'b1;
        send(1, 0, 8'h7E);
        chk_eq("t3_reload_vld", 32'(cmd_vld), 32'd1);
        chk_eq("t3_reload_dat", 32'(cmd_dat), 32'h7E);
        tick();
        chk_eq("t3_cmd_drain", 32'(cmd_vld), 32'd0);
        cmd_rdy = 1'b0;
        chk_eq("t3_num", 32'(pkt_num), 32'd4);

        // Fill the FIFO without lst; 17th beat must stall, even with a pop pending
        for (int i = 1; i <= 16; i++) send(0, 0, 8'(i));
        chip_dat_vld = 1'b1;
        chip_dat_dat = 8'd17;
        #1;
        chk_eq("t4_full_rdy", 32'(chip_dat_rdy), 32'd0);
        pkt_rdy = 1'b1;
        #1;
        chk_eq("t4_pop_no_push", 32'(chip_dat_rdy), 32'd0);
        chk_eq("t4_head0", pkt_dat, 32'h04030201);
        chk_eq("t4_head0_lst", 32'(pkt_lst), 32'd0);
        chip_dat_vld = 1'b0;
        tick();
        pkt_rdy = 1'b0;
        pop_word("t4_w1", 32'h08070605, 3'd4, 1'b0);
        pop_word("t4_w2", 32'h0C0B0A09, 3'd4, 1'b0);
        pop_word("t4_w3", 32'h100F0E0D, 3'd4, 1'b0);
        chk_eq("t4_drained", 32'(pkt_vld), 32'd0);
        send(0, 0, 8'd17);
        send(0, 0, 8'd18);
        send(0, 0, 8'd19);
        send(0, 1, 8'd20);
        pop_word("t4_w4", 32'h14131211, 3'd4, 1'b1);
        chk_eq("t4_num", 32'(pkt_num), 32'd5);

        // Reset mid-packet with a pending command
        send(1, 0, 8'h99);
        send(0, 0, 8'h31);
        send(0, 0, 8'h32);
        send(0, 0, 8'h33);
        rst = 1'b1;
        tick();
        chk_eq("t5_pkt_vld", 32'(pkt_vld), 32'd0);
        chk_eq("t5_cmd_vld", 32'(cmd_vld), 32'd0);
        chk_eq("t5_cmd_dat", 32'(cmd_dat), 32'd0);
        chk_eq("t5_pkt_num", 32'(pkt_num), 32'd0);
        chk_eq("t5_pkt_dat", pkt_dat, 32'd0);
        rst = 1'b0;
        tick();
        send(0, 0, 8'h01);
        send(0, 0, 8'h02);
        send(0, 0, 8'h03);
        send(0, 1, 8'h04);
        pop_word("t5", 32'h04030201, 3'd4, 1'b1);
        chk_eq("t5_num", 32'(pkt_num), 32'd1);

        // Stream single-beat packets until pkt_num wraps
        acc = 0;
        n = 0;
        pkt_rdy = 1'b1;
        chip_dat_vld = 1'b1;
        chip_dat_cmd = 1'b0;
        chip_dat_lst = 1'b1;
        #1;
        while (acc < 65534 && n < 70000) begin
            chip_dat_dat = 8'(acc);
            #1;
            if (chip_dat_rdy) acc++;
            tick();
            n++;
        end
        chip_dat_vld = 1'b0;
        chip_dat_lst = 1'b0;
        chk_eq("t6_rate", 32'(n), 32'd65534);
        n = 0;
        while (pkt_vld && n < 20) begin
            tick();
            n++;
        end
        pkt_rdy = 1'b0;
        chk_eq("t6_num_max", 32'(pkt_num), 32'hFFFF);
        send(0, 1, 8'hEE);
        pop_word("t6_last", 32'h000000EE, 3'd1, 1'b1);
        chk_eq("t6_num_wrap", 32'(pkt_num), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
